// File: rtl/ir_load_arbiter_if.sv
// Bus between the fetch sources and the instruction-register load arbiter.
//
// Handshake: each req bit is a level request that the source must hold until
// the matching grant bit pulses (grant is high for exactly one cycle, together
// with ir_load). Dropping req before the grant withdraws the request; dropping
// it after the grant has no effect on the load already in progress.
interface ir_load_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
);
    logic [N_REQ-1:0] req;
    logic [IDX_W-1:0] ir_index;
    logic             ir_load;
    logic [N_REQ-1:0] grant;
    logic             busy;
    logic [1:0]       state_dbg;

    // Requesters drive req and observe the arbiter's outputs.
    modport master (
        output req,
        input  ir_index, ir_load, grant, busy, state_dbg
    );

    // The arbiter samples req and drives the register select/strobe.
    modport slave (
        input  req,
        output ir_index, ir_load, grant, busy, state_dbg
    );
endinterface

// File: rtl/ir_load_arbiter.sv
// Round-robin arbiter sharing the instruction register between N_REQ fetch
// sources: one load strobe per grant, followed by HOLD_CYCLES quiet cycles so
// decode sees stable register contents.
module ir_load_arbiter #(
    parameter int N_REQ       = 4,
    parameter int IDX_W       = 2,
    parameter int HOLD_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    ir_load_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Hold counter preload; only used when there is a HOLD phase at all.
    localparam logic [7:0] HOLD_INIT = (HOLD_CYCLES > 0) ? 8'(HOLD_CYCLES - 1) : 8'd0;

    state_t           state;
    logic [7:0]       hold_cnt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ir_index_q;
    logic             ir_load_q;
    logic [N_REQ-1:0] grant_q;
    logic             busy_q;

    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Winner search: first set req bit starting just after the last winner,
    // wrapping modulo N_REQ, so the last winner has lowest priority.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        cand   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % N_REQ);
            if (!found && bus.req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            hold_cnt   <= 8'd0;
            ptr        <= IDX_W'(N_REQ - 1);
            ir_index_q <= '0;
            ir_load_q  <= 1'b0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state      <= LOAD;
                        ir_index_q <= winner;
                        ir_load_q  <= 1'b1;
                        grant_q    <= N_REQ'(1) << winner;
                        busy_q     <= 1'b1;
                        ptr        <= winner;
                    end
                end
                LOAD: begin
                    // The register captures data_in[ir_index] at this edge;
                    // ir_index is left alone so the select stays stable.
                    ir_load_q <= 1'b0;
                    grant_q   <= '0;
                    if (HOLD_CYCLES > 0) begin
                        state    <= HOLD;
                        hold_cnt <= HOLD_INIT;
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                HOLD: begin
                    if (hold_cnt == 8'd0) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    ir_load_q <= 1'b0;
                    grant_q   <= '0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ir_index  = ir_index_q;
    assign bus.ir_load   = ir_load_q;
    assign bus.grant     = grant_q;
    assign bus.busy      = busy_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_ir_load_arbiter.sv
// Directed bench for ir_load_arbiter: a HOLD_CYCLES=2 instance (b0) and a
// HOLD_CYCLES=0 instance (b1) share clock and reset.
module tb_ir_load_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    ir_load_arbiter_if #(.N_REQ(4), .IDX_W(2)) b0 ();
    ir_load_arbiter_if #(.N_REQ(4), .IDX_W(2)) b1 ();

    ir_load_arbiter #(.N_REQ(4), .IDX_W(2), .HOLD_CYCLES(2)) u_h2 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    ir_load_arbiter #(.N_REQ(4), .IDX_W(2), .HOLD_CYCLES(0)) u_h0 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        b0.req = 4'b1111;
        b1.req = 4'b0000;
        #3;
        checks++; if (b0.ir_index !== 2'd0) begin errors++; $display("FAIL reset_index: got %0d want 0", b0.ir_index); end
        checks++; if (b0.ir_load !== 1'b0) begin errors++; $display("FAIL reset_load: got %b want 0", b0.ir_load); end
        checks++; if (b0.grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", b0.grant); end
        checks++; if (b0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", b0.busy); end
        checks++; if (b0.state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", b0.state_dbg); end
        tick();
        checks++; if (b0.ir_load !== 1'b0) begin errors++; $display("FAIL reset_held_load: got %b want 0", b0.ir_load); end
        b0.req = 4'b0000;
        rst    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (b0.busy !== 1'b0 || b0.ir_load !== 1'b0 || b0.state_dbg !== 2'd0) begin
                errors++; $display("FAIL idle_after_reset c=%0d: busy=%b load=%b state=%0d want 0 0 0", i, b0.busy, b0.ir_load, b0.state_dbg);
            end
        end
    endtask

    task automatic test_single();
        logic exp_load [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic exp_busy [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        b0.req = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (b0.ir_load !== exp_load[i]) begin errors++; $display("FAIL single_load c=%0d: got %b want %b", i, b0.ir_load, exp_load[i]); end
            checks++; if (b0.busy !== exp_busy[i]) begin errors++; $display("FAIL single_busy c=%0d: got %b want %b", i, b0.busy, exp_busy[i]); end
            checks++; if (b0.ir_index !== 2'd2) begin errors++; $display("FAIL single_index c=%0d: got %0d want 2", i, b0.ir_index); end
            checks++; if (b0.grant !== (exp_load[i] ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL single_grant c=%0d: got %b", i, b0.grant); end
            if (i == 4) b0.req = 4'b0000;
        end
        tick();
        checks++; if (b0.ir_load !== 1'b0) begin errors++; $display("FAIL single_no_regrant: got %b want 0", b0.ir_load); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_grant;
        rst    = 1'b1;
        b0.req = 4'b1111;
        tick();
        rst = 1'b0;
        for (int g = 0; g < 5; g++) begin
            exp_grant = 4'b0001 << (g % 4);
            tick();
            checks++; if (b0.ir_load !== 1'b1) begin errors++; $display("FAIL rr_load g=%0d: got %b want 1", g, b0.ir_load); end
            checks++; if (b0.ir_index !== 2'(g % 4)) begin errors++; $display("FAIL rr_index g=%0d: got %0d want %0d", g, b0.ir_index, g % 4); end
            checks++; if (b0.grant !== exp_grant) begin errors++; $display("FAIL rr_grant g=%0d: got %b want %b", g, b0.grant, exp_grant); end
            for (int k = 0; k < 3; k++) begin
                tick();
                checks++; if (b0.ir_load !== 1'b0 || b0.grant !== 4'b0000) begin errors++; $display("FAIL rr_gap g=%0d k=%0d: load=%b grant=%b want 0 0000", g, k, b0.ir_load, b0.grant); end
                checks++; if (b0.ir_index !== 2'(g % 4)) begin errors++; $display("FAIL rr_index_hold g=%0d k=%0d: got %0d want %0d", g, k, b0.ir_index, g % 4); end
                checks++; if (b0.busy !== (k < 2)) begin errors++; $display("FAIL rr_busy g=%0d k=%0d: got %b want %b", g, k, b0.busy, k < 2); end
            end
        end
        b0.req = 4'b0000;
        tick();
    endtask

    task automatic test_wrap();
        #2;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        b0.req = 4'b0010;
        tick();
        checks++; if (b0.ir_index !== 2'd1 || b0.grant !== 4'b0010) begin errors++; $display("FAIL wrap_first: index=%0d grant=%b want 1 0010", b0.ir_index, b0.grant); end
        b0.req = 4'b0000;
        repeat (3) tick();
        b0.req = 4'b1010;
        tick();
        checks++; if (b0.ir_index !== 2'd3 || b0.grant !== 4'b1000 || b0.ir_load !== 1'b1) begin errors++; $display("FAIL wrap_to3: index=%0d grant=%b load=%b want 3 1000 1", b0.ir_index, b0.grant, b0.ir_load); end
        b0.req = 4'b0010;
        repeat (3) tick();
        tick();
        checks++; if (b0.ir_index !== 2'd1 || b0.grant !== 4'b0010 || b0.ir_load !== 1'b1) begin errors++; $display("FAIL wrap_to1: index=%0d grant=%b load=%b want 1 0010 1", b0.ir_index, b0.grant, b0.ir_load); end
        b0.req = 4'b0000;
        repeat (3) tick();
    endtask

    task automatic test_async_reset();
        // Reset while in HOLD.
        b0.req = 4'b1000;
        tick();
        b0.req = 4'b0000;
        tick();
        checks++; if (b0.busy !== 1'b1 || b0.state_dbg !== 2'd2) begin errors++; $display("FAIL hold_before_rst: busy=%b state=%0d want 1 2", b0.busy, b0.state_dbg); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (b0.busy !== 1'b0 || b0.ir_load !== 1'b0 || b0.grant !== 4'b0000) begin errors++; $display("FAIL rst_mid_hold: busy=%b load=%b grant=%b want 0 0 0000", b0.busy, b0.ir_load, b0.grant); end
        checks++; if (b0.ir_index !== 2'd0 || b0.state_dbg !== 2'd0) begin errors++; $display("FAIL rst_mid_hold_idx: index=%0d state=%0d want 0 0", b0.ir_index, b0.state_dbg); end
        b0.req = 4'b1111;
        #1;
        rst = 1'b0;
        tick();
        checks++; if (b0.ir_load !== 1'b1 || b0.ir_index !== 2'd0 || b0.grant !== 4'b0001) begin errors++; $display("FAIL rst_first_grant: load=%b index=%0d grant=%b want 1 0 0001", b0.ir_load, b0.ir_index, b0.grant); end
        b0.req = 4'b0000;
        repeat (3) tick();
        // Reset while the load strobe is high.
        b0.req = 4'b0100;
        tick();
        b0.req = 4'b0000;
        checks++; if (b0.ir_load !== 1'b1) begin errors++; $display("FAIL load_before_rst: got %b want 1", b0.ir_load); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (b0.ir_load !== 1'b0 || b0.grant !== 4'b0000 || b0.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_load: load=%b grant=%b busy=%b want 0 0000 0", b0.ir_load, b0.grant, b0.busy); end
        #1;
        rst = 1'b0;
        tick();
        checks++; if (b0.ir_load !== 1'b0 || b0.state_dbg !== 2'd0) begin errors++; $display("FAIL after_rst_idle: load=%b state=%0d want 0 0", b0.ir_load, b0.state_dbg); end
    endtask

    task automatic test_no_hold();
        b1.req = 4'b1111;
        for (int g = 0; g < 4; g++) begin
            tick();
            checks++; if (b1.ir_load !== 1'b1 || b1.ir_index !== 2'(g) || b1.grant !== (4'b0001 << g)) begin
                errors++; $display("FAIL h0_grant g=%0d: load=%b index=%0d grant=%b want 1 %0d %b", g, b1.ir_load, b1.ir_index, b1.grant, g, 4'b0001 << g);
            end
            tick();
            checks++; if (b1.ir_load !== 1'b0 || b1.busy !== 1'b0 || b1.ir_index !== 2'(g) || b1.state_dbg !== 2'd0) begin
                errors++; $display("FAIL h0_gap g=%0d: load=%b busy=%b index=%0d state=%0d want 0 0 %0d 0", g, b1.ir_load, b1.busy, b1.ir_index, b1.state_dbg, g);
            end
        end
        b1.req = 4'b0001;
        tick();
        b1.req = 4'b0000;
        checks++; if (b1.ir_load !== 1'b1 || b1.ir_index !== 2'd0 || b1.grant !== 4'b0001) begin errors++; $display("FAIL h0_drop_load: load=%b index=%0d grant=%b want 1 0 0001", b1.ir_load, b1.ir_index, b1.grant); end
        tick();
        checks++; if (b1.ir_load !== 1'b0 || b1.busy !== 1'b0 || b1.ir_index !== 2'd0) begin errors++; $display("FAIL h0_drop_done: load=%b busy=%b index=%0d want 0 0 0", b1.ir_load, b1.busy, b1.ir_index); end
        tick();
        checks++; if (b1.ir_load !== 1'b0) begin errors++; $display("FAIL h0_no_regrant: got %b want 0", b1.ir_load); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_async_reset();
        test_no_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
